// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
//   Shared definitions for the multiplier-sharing arbiter.
//   - state_t   : arbiter FSM state encoding
//   - clog2     : ceiling log2 (minimum 1) for requester-id and counter widths
//   - prod_w    : product width for a given operand width
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/mult_seq_core.sv
// -----------------------------------------------------------------------------
// mult_seq_core
//   Sequential signed multiplier datapath: sign/magnitude capture, DATA_W-step
//   unsigned shift-add, final two's-complement sign fix.
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   i_start       capture i_a/i_b magnitudes and product sign, clear accumulator
//   i_a, i_b      signed operands
//   i_step        one shift-add iteration
//   i_fix         apply sign to accumulator and register the product
//   o_last        the step in progress is the final iteration
//   o_res         registered signed product
// -----------------------------------------------------------------------------
module mult_seq_core
    import mult_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          i_start,
    input  logic [DATA_W-1:0]             i_a,
    input  logic [DATA_W-1:0]             i_b,
    input  logic                          i_step,
    input  logic                          i_fix,
    output logic                          o_last,
    output logic [prod_w(DATA_W)-1:0]     o_res
);

    localparam int PW    = prod_w(DATA_W);
    localparam int CNT_W = clog2(DATA_W);

    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic [PW-1:0]     r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [PW-1:0]     r_acc;
    logic              r_neg;
    logic [CNT_W-1:0]  r_cnt;
    logic [PW-1:0]     r_res;

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign w_abs_a = i_a[DATA_W-1] ? (~i_a + DATA_W'(1)) : i_a;
    assign w_abs_b = i_b[DATA_W-1] ? (~i_b + DATA_W'(1)) : i_b;

    assign o_last = (r_cnt == CNT_W'(DATA_W - 1));
    assign o_res  = r_res;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
        end else if (i_start) begin
            r_mcand  <= PW'(w_abs_a);
            r_mplier <= w_abs_b;
            r_acc    <= '0;
            r_neg    <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
            r_cnt    <= '0;
        end else if (i_step) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end else if (i_fix) begin
            // A zero magnitude stays zero regardless of sign.
            r_res <= (r_neg && (r_acc != '0)) ? (~r_acc + PW'(1)) : r_acc;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//   Shares one sequential signed multiplier between NUM_REQ requesters with
//   round-robin arbitration and a tagged valid/ready result.
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   REQ           per-requester request level (sampled in IDLE only)
//   REQ_A, REQ_B  packed operands, requester k at [k*DATA_W +: DATA_W]
//   GNT           one-hot, one-cycle pulse when a requester's operands are taken
//   RES_VALID     product valid, held until RES_READY
//   RES_READY     consumer accepts the product
//   RES_DATA      signed product
//   RES_ID        requester that owns RES_DATA
//   BUSY          high whenever the FSM is not idle
// Configuration
//   MULT_ARB_PRIO0_EN : requester 0 always wins when requesting; its grants do
//                       not move the round-robin pointer.
// -----------------------------------------------------------------------------
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*DATA_W-1:0]     REQ_A,
    input  logic [NUM_REQ*DATA_W-1:0]     REQ_B,
    output logic [NUM_REQ-1:0]            GNT,
    output logic                          RES_VALID,
    input  logic                          RES_READY,
    output logic [prod_w(DATA_W)-1:0]     RES_DATA,
    output logic [clog2(NUM_REQ)-1:0]     RES_ID,
    output logic                          BUSY
);

    localparam int ID_W = clog2(NUM_REQ);

    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic [ID_W-1:0]    r_rr_ptr;

    logic [NUM_REQ-1:0] w_rot;
    logic               w_found;
    logic [ID_W:0]      w_sum;
    logic [ID_W:0]      w_wrap;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W:0]      w_inc;
    logic [ID_W-1:0]    w_next_ptr;
    logic               w_start;
    logic               w_last;

    // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit
    // of the rotated vector is the round-robin winner.
    assign w_rot = NUM_REQ'({REQ, REQ} >> r_rr_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_sum    = '0;
        w_wrap   = '0;
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
            end
        end
`ifdef MULT_ARB_PRIO0_EN
        if (REQ[0]) begin
            w_found = 1'b1;
            w_sum   = '0;
        end
`endif
        w_wrap   = w_sum - (ID_W + 1)'(NUM_REQ);
        w_winner = (w_sum >= (ID_W + 1)'(NUM_REQ)) ? ID_W'(w_wrap) : ID_W'(w_sum);
    end

    assign w_inc      = {1'b0, r_res_id} + (ID_W + 1)'(1);
    assign w_next_ptr = (w_inc >= (ID_W + 1)'(NUM_REQ)) ? '0 : ID_W'(w_inc);

    assign w_start = (r_state == S_IDLE) && w_found;

    mult_seq_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .CLK     (CLK),
        .RST     (RST),
        .i_start (w_start),
        .i_a     (REQ_A[w_winner*DATA_W +: DATA_W]),
        .i_b     (REQ_B[w_winner*DATA_W +: DATA_W]),
        .i_step  (r_state == S_RUN),
        .i_fix   (r_state == S_FIX),
        .o_last  (w_last),
        .o_res   (RES_DATA)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= NUM_REQ'(1) << w_winner;
                        r_res_id <= w_winner;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_res_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_state     <= S_IDLE;
`ifdef MULT_ARB_PRIO0_EN
                        if (r_res_id != '0) r_rr_ptr <= w_next_ptr;
`else
                        r_rr_ptr <= w_next_ptr;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign GNT       = r_gnt;
    assign RES_VALID = r_res_valid;
    assign RES_ID    = r_res_id;
    assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Self-checking bench for mult_share_arbiter (NUM_REQ=4, DATA_W=8).
//   Honors MULT_ARB_PRIO0_EN in its reference model.
// -----------------------------------------------------------------------------
module tb_mult_share_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [31:0] REQ_A;
    logic [31:0] REQ_B;
    logic [3:0]  GNT;
    logic        RES_VALID;
    logic        RES_READY;
    logic [15:0] RES_DATA;
    logic [1:0]  RES_ID;
    logic        BUSY;

    mult_share_arbiter #(
        .NUM_REQ (4),
        .DATA_W  (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .GNT       (GNT),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .RES_DATA  (RES_DATA),
        .RES_ID    (RES_ID),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_ptr    = 0;
    int          last_win;
    logic [15:0] last_data;
    logic [3:0]  tb_req;
    logic [7:0]  tb_a [4];
    logic [7:0]  tb_b [4];
    logic [7:0]  corner [5];
    int          order [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: round-robin pick straight from the arbitration rule.
    function automatic int model_pick(input logic [3:0] r, input int ptr);
`ifdef MULT_ARB_PRIO0_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (((r >> ((ptr + k) % 4)) & 4'd1) != 4'd0) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_mul(input logic [7:0] a, input logic [7:0] b);
        int pa, pb, p;
        pa = int'($signed(a));
        pb = int'($signed(b));
        p  = pa * pb;
        return p[15:0];
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive();
        REQ   = tb_req;
        REQ_A = {tb_a[3], tb_a[2], tb_a[1], tb_a[0]};
        REQ_B = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},   GNT,       0);
        check({tag, "_valid"}, RES_VALID, 0);
        check({tag, "_data"},  RES_DATA,  0);
        check({tag, "_id"},    RES_ID,    0);
        check({tag, "_busy"},  BUSY,      0);
    endtask

    task automatic do_reset();
        RES_READY = 1'b0;
        RST = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        m_ptr = 0;
    endtask

    task automatic randomize_ops();
        for (int k = 0; k < 4; k++) begin
            tb_a[k] = 8'($urandom);
            tb_b[k] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) tb_a[k] = corner[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) tb_b[k] = corner[$urandom_range(0, 4)];
        end
    endtask

    // One full job: grant, latency, result, optional stall, accept.
    task automatic run_job(input int stall, input bit drop);
        int          exp_w;
        int          n;
        logic [15:0] exp_p;
        exp_w = model_pick(tb_req, m_ptr);
        n = 0;
        do begin
            step();
            n++;
        end while (GNT == 4'b0 && n < 6);
        check("gnt_wait", n, 1);
        check("gnt_onehot", GNT, 32'd1 << exp_w);
        if (GNT == 4'b0) begin
            last_win = -1;
            return;
        end
        exp_p = model_mul(tb_a[exp_w], tb_b[exp_w]);
        if (drop) tb_req = tb_req & ~(4'b1 << exp_w);
        tb_a[exp_w] = 8'($urandom);
        tb_b[exp_w] = 8'($urandom);
        drive();
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                check("gnt_pulse", GNT, 0);
                check("busy_run", BUSY, 1);
            end
        end while (!RES_VALID && n < 30);
        check("latency", n, 9);
        check("data", RES_DATA, exp_p);
        check("id", RES_ID, exp_w);
        last_data = RES_DATA;
        for (int s = 0; s < stall; s++) begin
            step();
            check("hold_valid", RES_VALID, 1);
            check("hold_data", RES_DATA, exp_p);
            check("hold_id", RES_ID, exp_w);
            check("hold_gnt", GNT, 0);
        end
        RES_READY = 1'b1;
        step();
        RES_READY = 1'b0;
        check("valid_clr", RES_VALID, 0);
        check("gnt_gap", GNT, 0);
`ifdef MULT_ARB_PRIO0_EN
        if (exp_w != 0) m_ptr = (exp_w + 1) % 4;
`else
        m_ptr = (exp_w + 1) % 4;
`endif
        last_win = exp_w;
    endtask

    initial begin
        corner[0] = 8'h80; corner[1] = 8'h7F; corner[2] = 8'hFF;
        corner[3] = 8'h00; corner[4] = 8'h01;
        RST = 1'b1;
        RES_READY = 1'b0;
        tb_req = 4'b0;
        for (int k = 0; k < 4; k++) begin
            tb_a[k] = 8'h00;
            tb_b[k] = 8'h00;
        end
        drive();
        #1;
        check_reset_outputs("por");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Single requester 2: 7 * 6.
        tb_req = 4'b0100;
        tb_a[2] = 8'd7;
        tb_b[2] = 8'd6;
        drive();
        run_job(0, 1);
        check("single_data", last_data, 16'd42);
        check("single_win", last_win, 2);

        // All requesters held: fixed grant order from reset.
        do_reset();
`ifdef MULT_ARB_PRIO0_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        tb_req = 4'b1111;
        randomize_ops();
        drive();
        for (int j = 0; j < 5; j++) begin
            run_job(0, 0);
            check("order_1111", last_win, order[j]);
        end

        // Signed corners on requester 1.
        do_reset();
        tb_req = 4'b0010; tb_a[1] = 8'h80; tb_b[1] = 8'h80; drive();
        run_job(0, 1);
        check("c_m128_m128", last_data, 16'h4000);
        tb_req = 4'b0010; tb_a[1] = 8'h80; tb_b[1] = 8'h7F; drive();
        run_job(0, 1);
        check("c_m128_127", last_data, 16'hC080);
        tb_req = 4'b0010; tb_a[1] = 8'hFF; tb_b[1] = 8'h01; drive();
        run_job(0, 1);
        check("c_m1_1", last_data, 16'hFFFF);
        tb_req = 4'b0010; tb_a[1] = 8'h00; tb_b[1] = 8'hFB; drive();
        run_job(0, 1);
        check("c_0_m5", last_data, 16'h0000);

        // Long consumer stall with another request pending.
        tb_req = 4'b0101;
        randomize_ops();
        drive();
        run_job(20, 1);
        run_job(0, 1);

        // Reset in the middle of RUN discards the job.
        do_reset();
        tb_req = 4'b1111;
        randomize_ops();
        drive();
        step();
        check("mid_gnt", GNT, 4'b0001);
        for (int s = 0; s < 4; s++) step();
        check("mid_busy", BUSY, 1);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(posedge CLK);
        #1;
        RST   = 1'b0;
        m_ptr = 0;
        run_job(0, 0);
        check("mid_regrant", last_win, 0);

        // Requesters 0,1,3 held.
        do_reset();
`ifdef MULT_ARB_PRIO0_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 3, 0, 1};
`endif
        tb_req = 4'b1011;
        randomize_ops();
        drive();
        for (int j = 0; j < 4; j++) begin
            run_job(0, 0);
            check("order_1011", last_win, order[j]);
        end

        // Randomized traffic.
        do_reset();
        tb_req = 4'b0;
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 2) == 0) tb_req = tb_req | 4'($urandom_range(0, 15));
            if (tb_req == 4'b0) tb_req = 4'($urandom_range(1, 15));
            randomize_ops();
            drive();
            run_job($urandom_range(0, 3), 1);
        end
        tb_req = 4'b0;
        drive();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
